// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IF fetch and MEM load/store.
// Build option MEM_ARB_RR_EN: round-robin instead of data-first priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;
  logic              err_q, err_d;

  logic              if_ok, d_ok;
  logic              gnt_if, gnt_d;
  logic              tmo, done;
  logic [DATA_W-1:0] rdata;

  // A requester whose ack is high this cycle is still holding its old req.
  assign if_ok = if_req_i & ~if_ack_q;
  assign d_ok  = d_req_i & ~d_ack_q;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
  assign gnt_d = d_ok & (~if_ok | ~last_d_q);
`else
  assign gnt_d = d_ok;
`endif
  assign gnt_if = if_ok & ~gnt_d;

  assign tmo   = (cnt_q == LAST) & ~mem_ready_i;
  assign done  = mem_ready_i | tmo;
  assign rdata = mem_ready_i ? mem_rdata_i : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_ack_d = 1'b0;
    d_ack_d  = 1'b0;
    if_rd_d  = if_rd_q;
    d_rd_d   = d_rd_q;
    err_d    = err_q;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_d) begin
          state_d = D_ACC;
          en_d    = 1'b1;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (gnt_if) begin
          state_d = IF_ACC;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      IF_ACC, D_ACC: begin
        if (done) begin
          state_d = IDLE;
          en_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = err_q | tmo;
          if (state_q == IF_ACC) begin
            if_ack_d = 1'b1;
            if_rd_d  = rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rd_d = rdata;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      if_ack_q <= if_ack_d;
      d_ack_q  <= d_ack_d;
      if_rd_q  <= if_rd_d;
      d_rd_q   <= d_rd_d;
      err_q    <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_d_q <= 1'b0;
    else         last_d_q <= last_d_d;
  end
`endif

  assign if_rdata_o  = if_rd_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rd_q;
  assign d_ack_o     = d_ack_q;
  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule
